// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the framebuffer write scheduler.
package fb_sched_pkg;

  localparam int PIXEL_W = 4;
  localparam logic [PIXEL_W-1:0] FILL_VALUE = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    PTR_RST,
    STREAM,
    STROBE,
    GAP,
    EXIT
  } state_t;

endpackage

// File: rtl/fb_sched_match.sv
// Finds the requester whose index equals next_idx; the lowest core number wins ties.
module fb_sched_match
  import fb_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 15
) (
  input  logic [NUM_CORES-1:0]         req,
  input  logic [NUM_CORES*IDX_W-1:0]   req_idx,
  input  logic [NUM_CORES*PIXEL_W-1:0] req_val,
  input  logic [IDX_W-1:0]             next_idx,
  output logic                         hit,
  output logic [NUM_CORES-1:0]         grant,
  output logic [PIXEL_W-1:0]           sel_val
);

  always_comb begin
    hit     = 1'b0;
    grant   = '0;
    sel_val = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!hit && req[i] && (req_idx[i*IDX_W +: IDX_W] == next_idx)) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
        sel_val  = req_val[i*PIXEL_W +: PIXEL_W];
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Drives one framebuffer frame write in strict raster order from out-of-order pixel engines.
// Fill-on-timeout for a stalled pixel is enabled by defining FB_WRITE_SCHED_TIMEOUT_EN.
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int NUM_PIXELS   = 19200,
  parameter int IDX_W        = 15,
  parameter int RESET_CYCLES = 2,
  parameter int WRITE_GAP    = 3,
  parameter int TIMEOUT      = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [NUM_CORES-1:0]         req,
  input  logic [NUM_CORES*IDX_W-1:0]   req_idx,
  input  logic [NUM_CORES*PIXEL_W-1:0] req_val,
  output logic [NUM_CORES-1:0]         ack,
  output logic                         fb_write_mode,
  output logic [PIXEL_W-1:0]           fb_write_data_in,
  output logic                         fb_reset_write_ptr,
  output logic                         fb_write_data,
  input  logic                         fb_wrote_data,
  output logic                         err_timeout
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(WRITE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     next_idx_q, next_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic                 mode_q, mode_d;
  logic [PIXEL_W-1:0]   data_in_q, data_in_d;
  logic                 ptr_rst_q, ptr_rst_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;

  logic                 hit;
  logic [NUM_CORES-1:0] grant;
  logic [PIXEL_W-1:0]   sel_val;
  logic                 fill;

  fb_sched_match #(
    .NUM_CORES(NUM_CORES),
    .IDX_W    (IDX_W)
  ) u_match (
    .req     (req),
    .req_idx (req_idx),
    .req_val (req_val),
    .next_idx(next_idx_q),
    .hit     (hit),
    .grant   (grant),
    .sel_val (sel_val)
  );

`ifdef FB_WRITE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts unmatched STREAM cycles; the TIMEOUT-th one forces a fill write instead of waiting.
  always_comb begin
    to_cnt_d = '0;
    fill     = 1'b0;
    if (state_q == STREAM && !hit) begin
      if (to_cnt_q == TO_LAST) fill = 1'b1;
      else                     to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign fill           = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      next_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= '0;
      mode_q     <= 1'b0;
      data_in_q  <= '0;
      ptr_rst_q  <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      next_idx_q <= next_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      mode_q     <= mode_d;
      data_in_q  <= data_in_d;
      ptr_rst_q  <= ptr_rst_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    next_idx_d = next_idx_q;
    case (state_q)
      IDLE:    if (start) state_d = ENTER;
      ENTER: begin
        if (fb_wrote_data) begin
          state_d = PTR_RST;
          cnt_d   = '0;
        end
      end
      PTR_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d    = STREAM;
          next_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM:  if (hit || fill) state_d = STROBE;
      STROBE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          next_idx_d = next_idx_q + IDX_W'(1);
          state_d    = (next_idx_q == LAST_IDX) ? EXIT : STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    busy_d    = (state_d != IDLE) && (state_d != EXIT);
    mode_d    = (state_d != IDLE) && (state_d != EXIT);
    done_d    = (state_d == EXIT);
    ptr_rst_d = (state_d == PTR_RST);
    strobe_d  = (state_d == STROBE);
    ack_d     = '0;
    data_in_d = data_in_q;
    err_d     = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    if (state_q == STREAM) begin
      if (hit) begin
        ack_d     = grant;
        data_in_d = sel_val;
      end else if (fill) begin
        data_in_d = FILL_VALUE;
        err_d     = 1'b1;
      end
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign ack                = ack_q;
  assign fb_write_mode      = mode_q;
  assign fb_write_data_in   = data_in_q;
  assign fb_reset_write_ptr = ptr_rst_q;
  assign fb_write_data      = strobe_q;
  assign err_timeout        = err_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler with a 4-pixel frame and a behavioural framebuffer/requester model.
module tb_fb_write_scheduler;

  localparam int NC = 4;
  localparam int IW = 15;
  localparam int NP = 4;
`ifdef FB_WRITE_SCHED_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 4095;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, fb_write_mode, fb_reset_write_ptr, fb_write_data, err_timeout;
  logic [NC-1:0]   req = '0;
  logic [NC*IW-1:0] req_idx = '0;
  logic [NC*4-1:0] req_val = '0;
  logic [NC-1:0]   ack;
  logic [3:0]      fb_write_data_in;
  logic            fb_wrote_data = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_write_scheduler #(
    .NUM_CORES(NC), .NUM_PIXELS(NP), .IDX_W(IW),
    .RESET_CYCLES(2), .WRITE_GAP(3), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .req(req), .req_idx(req_idx), .req_val(req_val), .ack(ack),
    .fb_write_mode(fb_write_mode), .fb_write_data_in(fb_write_data_in),
    .fb_reset_write_ptr(fb_reset_write_ptr), .fb_write_data(fb_write_data),
    .fb_wrote_data(fb_wrote_data), .err_timeout(err_timeout)
  );

  // Requester tables (owned by the tasks); entries are consumed as acks arrive.
  logic [IW-1:0] c_idx [NC][8];
  logic [3:0]    c_val [NC][8];
  int            c_base [NC] = '{default: 0};
  int            c_tail [NC] = '{default: 0};

  // Event log (owned by the monitor).
  int         cyc = 0;
  int         wr_n = 0, ack_n = 0, done_n = 0, rp_n = 0;
  int         wr_cyc [64];
  logic [3:0] wr_val [64];
  logic [3:0] ack_oh [64];
  int         ack_cnt [NC] = '{default: 0};
  int         done_cyc = 0;
  logic       done_mode = 1'b0, done_busy = 1'b0;
  int         mode_rise = -100;
  logic       mode_prev = 1'b0, rp_prev = 1'b0;
  int         stream_cyc = 0;

  always @(posedge clk) begin
    int head;
    #1;
    cyc = cyc + 1;
    if (fb_write_data === 1'b1 && wr_n < 64) begin
      wr_cyc[wr_n] = cyc;
      wr_val[wr_n] = fb_write_data_in;
      wr_n = wr_n + 1;
    end
    if ((|ack) === 1'b1 && ack_n < 64) begin
      ack_oh[ack_n] = ack;
      ack_n = ack_n + 1;
      for (int i = 0; i < NC; i++) if (ack[i]) ack_cnt[i] = ack_cnt[i] + 1;
    end
    if (done === 1'b1) begin
      done_n    = done_n + 1;
      done_cyc  = cyc;
      done_mode = fb_write_mode;
      done_busy = busy;
    end
    if (fb_reset_write_ptr === 1'b1) rp_n = rp_n + 1;
    if (rp_prev && fb_reset_write_ptr === 1'b0) stream_cyc = cyc;
    rp_prev = (fb_reset_write_ptr === 1'b1);
    if (fb_write_mode === 1'b1 && !mode_prev) mode_rise = cyc;
    mode_prev = (fb_write_mode === 1'b1);
    fb_wrote_data = (fb_write_mode === 1'b1) && (cyc == mode_rise + 16);
    for (int i = 0; i < NC; i++) begin
      head = ack_cnt[i] - c_base[i];
      if (head < c_tail[i] && head < 8) begin
        req[i] = 1'b1;
        req_idx[i*IW +: IW] = c_idx[i][head];
        req_val[i*4 +: 4]   = c_val[i][head];
      end else begin
        req[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cores();
    for (int i = 0; i < NC; i++) begin
      c_base[i] = ack_cnt[i];
      c_tail[i] = 0;
    end
    tick();
    tick();
  endtask

  task automatic push(input int core, input int idx, input logic [3:0] val);
    c_idx[core][c_tail[core]] = IW'(idx);
    c_val[core][c_tail[core]] = val;
    c_tail[core] = c_tail[core] + 1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_n == d0; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, fb_write_mode, fb_reset_write_ptr, fb_write_data, err_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, done, fb_write_mode, fb_reset_write_ptr, fb_write_data, err_timeout});
    end
    checks++;
    if ({ack, fb_write_data_in} !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h expected 00", {ack, fb_write_data_in});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int w0, d0, r0, a0, c0;
    logic [3:0] exp [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, exp[k]);
    tick();
    w0 = wr_n; d0 = done_n; r0 = rp_n; a0 = ack_cnt[0]; c0 = cyc;
    pulse_start();
    wait_done(d0, 300);
    checks++;
    if (done_n - d0 != 1) begin failures++; $display("FAIL frame_done: got %0d expected 1", done_n - d0); end
    checks++;
    if (rp_n - r0 != 2) begin failures++; $display("FAIL frame_ptr_rst_len: got %0d expected 2", rp_n - r0); end
    checks++;
    if (wr_n - w0 != 4) begin failures++; $display("FAIL frame_writes: got %0d expected 4", wr_n - w0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_val[w0+k] !== exp[k]) begin
        failures++; $display("FAIL frame_val%0d: got %h expected %h", k, wr_val[w0+k], exp[k]);
      end
    end
    checks++;
    if (wr_cyc[w0] - c0 != 21) begin failures++; $display("FAIL frame_latency: got %0d expected 21", wr_cyc[w0] - c0); end
    checks++;
    if (wr_cyc[w0] - stream_cyc != 1) begin
      failures++; $display("FAIL frame_stream_to_write: got %0d expected 1", wr_cyc[w0] - stream_cyc);
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (wr_cyc[w0+k] - wr_cyc[w0+k-1] != 5) begin
        failures++; $display("FAIL frame_slot%0d: got %0d expected 5", k, wr_cyc[w0+k] - wr_cyc[w0+k-1]);
      end
    end
    checks++;
    if (done_cyc - wr_cyc[w0+3] != 4) begin
      failures++; $display("FAIL frame_done_delay: got %0d expected 4", done_cyc - wr_cyc[w0+3]);
    end
    checks++;
    if ({done_mode, done_busy} !== 2'b00) begin
      failures++; $display("FAIL frame_exit_mode_busy: got %b expected 00", {done_mode, done_busy});
    end
    checks++;
    if (ack_cnt[0] - a0 != 4) begin failures++; $display("FAIL frame_acks: got %0d expected 4", ack_cnt[0] - a0); end
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL frame_err: got %b expected 0", err_timeout); end
  endtask

  task automatic test_out_of_order();
    int w0, d0, a0;
    logic [3:0] exp [4] = '{4'h3, 4'h9, 4'h1, 4'h2};
    clear_cores();
    push(0, 1, 4'h9); push(0, 2, 4'h1); push(0, 3, 4'h2);
    push(1, 0, 4'h3);
    tick();
    w0 = wr_n; d0 = done_n; a0 = ack_n;
    pulse_start();
    wait_done(d0, 300);
    checks++;
    if (ack_oh[a0] !== 4'b0010) begin failures++; $display("FAIL ooo_ack0: got %b expected 0010", ack_oh[a0]); end
    checks++;
    if (ack_oh[a0+1] !== 4'b0001) begin failures++; $display("FAIL ooo_ack1: got %b expected 0001", ack_oh[a0+1]); end
    checks++;
    if (ack_n - a0 != 4) begin failures++; $display("FAIL ooo_ack_count: got %0d expected 4", ack_n - a0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_val[w0+k] !== exp[k]) begin
        failures++; $display("FAIL ooo_val%0d: got %h expected %h", k, wr_val[w0+k], exp[k]);
      end
    end
  endtask

  task automatic test_tie();
    int w0, d0, a0, a2;
    logic [3:0] exp [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, exp[k]);
    push(2, 0, 4'hA);
    tick();
    w0 = wr_n; d0 = done_n; a0 = ack_n; a2 = ack_cnt[2];
    pulse_start();
    wait_done(d0, 300);
    checks++;
    if (ack_oh[a0] !== 4'b0001) begin failures++; $display("FAIL tie_ack0: got %b expected 0001", ack_oh[a0]); end
    checks++;
    if (ack_cnt[2] - a2 != 0) begin failures++; $display("FAIL tie_core2_acks: got %0d expected 0", ack_cnt[2] - a2); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_val[w0+k] !== exp[k]) begin
        failures++; $display("FAIL tie_val%0d: got %h expected %h", k, wr_val[w0+k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0, d0, r0;
    logic [3:0] exp [4] = '{4'hC, 4'hD, 4'hE, 4'hF};
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, 4'(k + 1));
    tick();
    w0 = wr_n;
    pulse_start();
    for (int k = 0; k < 300 && wr_n - w0 < 2; k++) tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, fb_write_mode, fb_reset_write_ptr, fb_write_data, ack, fb_write_data_in} !== 13'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got %b expected 0",
               {busy, done, fb_write_mode, fb_reset_write_ptr, fb_write_data, ack, fb_write_data_in});
    end
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (wr_n - w0 != 2) begin failures++; $display("FAIL midrst_no_strobe: got %0d expected 2", wr_n - w0); end
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, exp[k]);
    tick();
    w0 = wr_n; d0 = done_n; r0 = rp_n;
    pulse_start();
    wait_done(d0, 300);
    checks++;
    if (done_n - d0 != 1) begin failures++; $display("FAIL midrst_done: got %0d expected 1", done_n - d0); end
    checks++;
    if (rp_n - r0 != 2) begin failures++; $display("FAIL midrst_ptr_rst: got %0d expected 2", rp_n - r0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_val[w0+k] !== exp[k]) begin
        failures++; $display("FAIL midrst_val%0d: got %h expected %h", k, wr_val[w0+k], exp[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int w0, d0;
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, 4'(k + 10));
    tick();
    w0 = wr_n; d0 = done_n;
    pulse_start();
    repeat (30) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b expected 1", busy); end
    pulse_start();
    wait_done(d0, 300);
    repeat (40) tick();
    checks++;
    if (done_n - d0 != 1) begin failures++; $display("FAIL busy_done_count: got %0d expected 1", done_n - d0); end
    checks++;
    if (wr_n - w0 != 4) begin failures++; $display("FAIL busy_writes: got %0d expected 4", wr_n - w0); end
    checks++;
    if ({busy, fb_write_mode} !== 2'b00) begin
      failures++; $display("FAIL busy_idle_after: got %b expected 00", {busy, fb_write_mode});
    end
  endtask

`ifdef FB_WRITE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int w0, d0, a0;
    logic [3:0] exp [4] = '{4'h0, 4'h3, 4'h4, 4'h5};
    clear_cores();
    push(0, 1, 4'h3); push(0, 2, 4'h4); push(0, 3, 4'h5);
    tick();
    w0 = wr_n; d0 = done_n; a0 = ack_n;
    pulse_start();
    wait_done(d0, 400);
    checks++;
    if (wr_cyc[w0] - stream_cyc != 20) begin
      failures++; $display("FAIL to_delay: got %0d expected 20", wr_cyc[w0] - stream_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_val[w0+k] !== exp[k]) begin
        failures++; $display("FAIL to_val%0d: got %h expected %h", k, wr_val[w0+k], exp[k]);
      end
    end
    checks++;
    if (ack_n - a0 != 3) begin failures++; $display("FAIL to_acks: got %0d expected 3", ack_n - a0); end
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_err_sticky: got %b expected 1", err_timeout); end
    clear_cores();
    for (int k = 0; k < 4; k++) push(0, k, 4'(k + 1));
    tick();
    d0 = done_n;
    pulse_start();
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_err_clear: got %b expected 0", err_timeout); end
    wait_done(d0, 300);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_out_of_order();
    test_tie();
    test_reset_mid_frame();
    test_start_while_busy();
`ifdef FB_WRITE_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
Sequences the QSPI framebuffer write port for one frame. NUM_CORES Mandelbrot pixel engines produce 4-bit gray results out of order. The framebuffer pointer only auto-increments, so this block accepts results strictly in raster order, one per write slot, and drives the framebuffer write port.
It handles the full write sequence: enter write mode, reset the pointer, stream pixels, exit write mode. It sits between the pixel-engine array and the framebuffer VGA driver's write inputs.

Parameters:
NUM_CORES, 4, number of pixel-engine requesters
NUM_PIXELS, 19200, pixels per frame (160x120)
IDX_W, 15, pixel index width; must satisfy 2**IDX_W >= NUM_PIXELS
RESET_CYCLES, 2, cycles fb_reset_write_ptr is held high
WRITE_GAP, 3, idle cycles after each fb_write_data pulse (QSPI RAM latency)
TIMEOUT, 4095, STREAM cycles without a matching request before a fill write (TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begin a frame
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after write mode is left
req  in  NUM_CORES  request valid per core
req_idx  in  NUM_CORES*IDX_W  pixel index per core; core i at [i*IDX_W +: IDX_W]
req_val  in  NUM_CORES*4  gray value per core; core i at [i*4 +: 4]
ack  out  NUM_CORES  one-hot one-cycle accept pulse
fb_write_mode  out  1  to framebuffer write_mode
fb_write_data_in  out  4  pixel value to framebuffer
fb_reset_write_ptr  out  1  framebuffer pointer reset
fb_write_data  out  1  one-cycle write strobe
fb_wrote_data  in  1  pulse from framebuffer: write mode entered
err_timeout  out  1  sticky fill-write flag; cleared on start (TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (rst=1 at posedge), any time including mid-frame: state=IDLE, next_idx=0, all outputs 0.
  - fb_write_mode drops the next cycle; no partial strobe.
- All outputs are registered.
- IDLE:
  - start=1 -> ENTER, busy=1, err_timeout cleared.
  - start while busy is ignored.
- ENTER: fb_write_mode=1; wait for fb_wrote_data=1 -> PTR_RST.
  - No timeout in ENTER.
- PTR_RST: fb_reset_write_ptr=1 for exactly RESET_CYCLES cycles, then 0 -> STREAM, next_idx=0.
- STREAM, selection: a core matches when req[i]=1 and req_idx[i]==next_idx; the lowest i among matches wins.
- STREAM, on a win:
  - ack[i]=1 for one cycle.
  - fb_write_data_in latches req_val[i] in the same cycle.
  - -> STROBE.
- STREAM, no match: stay.
  - Non-matching requests are never acked.
  - Requesters hold req/idx/val until acked.
- STROBE: fb_write_data=1 for one cycle; fb_write_data_in stays stable -> GAP.
- GAP: WRITE_GAP cycles with fb_write_data=0, then next_idx += 1.
  - If the written index was NUM_PIXELS-1 -> EXIT, else -> STREAM.
- EXIT: fb_write_mode=0, busy=0, done=1 for one cycle -> IDLE.
- Write-slot length is 2+WRITE_GAP cycles minimum: 5 at default.
- Latency: start to first fb_write_data = 1 + ENTER wait + RESET_CYCLES + 2, with fb_wrote_data arriving 16 cycles after fb_write_mode rises.
- next_idx wraps to 0 only via a new frame.
  - An idx >= NUM_PIXELS never matches; with TIMEOUT_EN it eventually triggers a fill write.
- fb_write_data_in holds its last value between writes.

Optional Feature:
Macro FB_WRITE_SCHED_TIMEOUT_EN.
- Defined: a counter runs in STREAM and clears on each accept. When it reaches TIMEOUT:
  - write value 4'h0 for next_idx with no ack (STROBE/GAP as normal);
  - set err_timeout (sticky until next start).
  - This prevents a hung core from stalling VGA refresh.
- Not defined: no counter; STREAM waits indefinitely; err_timeout tied 0.

Decomposition:
- Shared package fb_sched_pkg holds:
  - state encoding: IDLE, ENTER, PTR_RST, STREAM, STROBE, GAP, EXIT;
  - FILL_VALUE = 4'h0;
  - PIXEL_W = 4.
- One sub-module, fb_sched_match: combinational index comparator plus fixed-priority one-hot select over NUM_CORES. Outputs hit, grant one-hot and the selected value.
- Counters stay in the top module.

Test Plan:
- NUM_PIXELS=4. start; fb_wrote_data 16 cycles after fb_write_mode rises; one core supplies idx 0..3 with values 5,6,7,8 -> fb_reset_write_ptr high 2 cycles, four fb_write_data pulses with fb_write_data_in 5,6,7,8 spaced 5 cycles, then done pulse and fb_write_mode=0.
- Out of order: core0 holds idx 1 (val 9) and core1 holds idx 0 (val 3) from the start -> ack[1] first with write 3, then ack[0] with write 9.
- Tie: core0 and core2 both present idx 0 -> ack=4'b0001 only; core2 stays pending and is never acked for idx 0.
- rst asserted in GAP after the second write -> next cycle all outputs 0; a new start replays from PTR_RST with next_idx 0.
- start pulsed while busy -> ignored; exactly one done per frame.
- With FB_WRITE_SCHED_TIMEOUT_EN, TIMEOUT=20, no requests in STREAM -> after 20 cycles fb_write_data pulses with value 0, no ack, err_timeout=1 until next start.
